checker_stream_arbiter: RTL and testbench
=========================================

Name: checker_stream_arbiter

Overview:
- Shares one character-serial cpu_checker between NREQ requesters, each sending trace messages such as "^242@000030f4: $31 <= 12345678#".
- Serialises whole messages onto chk_char and never interleaves them; each message ends with its terminating '#'.
- Routes the checker's format_type verdict back to the requester that owned the message.
- Sits between trace sources (CPU models, replay buffers) and the checker.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_LEN, 64, maximum characters per message, counting '^' and '#'.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- req_valid  in  NREQ  requester i has a character on req_char[i].
- req_char  in  8*NREQ  character lanes; lane i is bits [8i+7:8i].
- req_ready  out  NREQ  character accepted on this edge when valid&ready.
- res_valid  out  NREQ  one-cycle verdict strobe to the owning requester.
- res_type  out  2  checker verdict: 0 invalid, 1 register write, 2 memory write.
- res_abort  out  1  qualifies res_valid; message was dropped by the arbiter.
- chk_char  out  8  character to the checker.
- chk_format_type  in  2  checker output.
- busy  out  1  state is not IDLE.
- grant_id  out  clog2(NREQ)  current or most recent owner.

Behaviour:
- Reset (reset==0 at an edge) puts every output to 0, state to IDLE, and rr_ptr to NREQ-1.
- Reset mid-message silently discards that message; no res_valid is produced.
- The checker consumes one character per clock, so chk_char is registered. It is 8'h00 (neutral) in every cycle without a transfer.
- States and transitions:
  - IDLE: round-robin search starting at rr_ptr+1 over req_valid. On a hit, register grant_id, set rr_ptr to that id, clear len_cnt, go to STREAM. No character is accepted in IDLE.
  - STREAM: req_ready[grant_id]=1, all other bits 0.
    - Transfer when req_valid[grant_id]: chk_char <= char and len_cnt++.
    - Transferred char=='#': go to DRAIN.
    - Transferred char!='#' with len_cnt+1==MAX_LEN: go to ABORT.
    - No transfer (bubble): chk_char <= 00, go to ABORT. A bubble would corrupt the checker's parse.
  - DRAIN: chk_char carries '#' this cycle and the checker updates at the closing edge. Go to CAPTURE.
  - CAPTURE: sample chk_format_type into res_type. Assert res_valid[grant_id]=1 with res_abort=0 for the next cycle. Go to IDLE.
  - ABORT: chk_char=00 for one cycle so the checker returns to idle. Assert res_valid[grant_id]=1 with res_abort=1 and res_type=0 for the next cycle. Go to IDLE.
- Latency: '#' accepted at edge t; res_valid is high during cycle t+2..t+3.
- IDLE may grant in the same cycle res_valid is high, so the message-to-message gap is 3 idle cycles on chk_char.
- res_type and grant_id hold their values until the next result.
- res_valid is one-hot or zero.
- Requesters that are not granted see req_ready=0. Their held characters are never forwarded.
- Round-robin fairness: with all requesters valid, grants cycle 0,1,..,NREQ-1,0.
- len_cnt width is clog2(MAX_LEN+1) and it never wraps, because ABORT fires first.

Decomposition:
- Shared package checker_pkg:
  - State encoding enum: IDLE, STREAM, DRAIN, CAPTURE, ABORT.
  - FMT_NONE=0, FMT_REG=1, FMT_MEM=2.
  - CH_START='^', CH_END='#', CH_NEUTRAL=8'h00.
- Sub-module rr_pick (NREQ): combinational one-hot round-robin picker, inputs req and ptr, outputs valid and index.

Test Plan:
- Requester 0 only, streams "^242@000030f4: $31 <= 12345678#" continuously:
  - chk_char reproduces the string 1 cycle delayed.
  - res_valid=01 and res_type=1 two cycles after '#' is accepted.
- Requester 1 sends "^338@00003130: *00000088 <= ffffb528#" -> res_valid=10, res_type=2, res_abort=0.
- Both requesters valid at once, three messages each:
  - Grant order is 0,1,0,1,0,1.
  - No interleaving on chk_char.
  - Each verdict reaches its own requester.
- Requester 0 drops req_valid for one cycle after "^242@00" -> chk_char=00, res_valid=01, res_abort=1, res_type=0, next grant to requester 1.
- A 70-character message without '#' at MAX_LEN=64 -> abort after the 64th accepted character; req_ready falls.
- reset=0 asserted mid-STREAM -> all outputs 0 on the next edge, no res_valid, first grant after release goes to requester 0.

Source files
------------

// File: rtl/checker_pkg.sv
// checker_pkg: arbiter state encoding, checker verdict codes and message framing characters
package checker_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        ABORT   = 3'd4
    } state_t;
    localparam logic [1:0] FMT_NONE   = 2'd0;
    localparam logic [1:0] FMT_REG    = 2'd1;
    localparam logic [1:0] FMT_MEM    = 2'd2;
    localparam logic [7:0] CH_START   = 8'h5e;
    localparam logic [7:0] CH_END     = 8'h23;
    localparam logic [7:0] CH_NEUTRAL = 8'h00;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; req (request bits), ptr (last owner) -> valid, index of first request after ptr, wrapping
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] index
);
    localparam int IW = $clog2(NREQ);
    logic hi_hit, lo_hit;
    logic [IW-1:0] hi_idx, lo_idx;
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && i > int'(ptr)) begin
                hi_hit = 1'b1;
                hi_idx = IW'(i);
            end
            if (req[i] && i <= int'(ptr)) begin
                lo_hit = 1'b1;
                lo_idx = IW'(i);
            end
        end
        valid = hi_hit | lo_hit;
        index = hi_hit ? hi_idx : lo_idx;
    end
endmodule

// File: rtl/checker_stream_arbiter.sv
// checker_stream_arbiter: serialises whole requester messages onto one cpu_checker; clk/reset, req_valid/req_char/req_ready lanes, chk_char/chk_format_type checker side, res_valid/res_type/res_abort verdicts, busy/grant_id status
module checker_stream_arbiter
    import checker_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MAX_LEN = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_char,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         res_valid,
    output logic [1:0]              res_type,
    output logic                    res_abort,
    output logic [7:0]              chk_char,
    input  logic [1:0]              chk_format_type,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IW = $clog2(NREQ);
    localparam int LW = $clog2(MAX_LEN + 1);
    state_t state;
    logic [IW-1:0] rr_ptr, pick_idx;
    logic pick_valid, cur_valid;
    logic [LW-1:0] len_cnt, len_nxt;
    logic [NREQ-1:0] grant_oh;
    logic [7:0] cur_char;
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );
    assign grant_oh  = NREQ'(1) << grant_id;
    assign cur_char  = req_char[8*grant_id +: 8];
    assign cur_valid = req_valid[grant_id];
    assign len_nxt   = len_cnt + LW'(1);
    assign req_ready = (state == STREAM) ? grant_oh : '0;
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= IW'(NREQ - 1);
            grant_id  <= '0;
            len_cnt   <= '0;
            chk_char  <= CH_NEUTRAL;
            res_valid <= '0;
            res_type  <= FMT_NONE;
            res_abort <= 1'b0;
        end else begin
            res_valid <= '0;
            chk_char  <= CH_NEUTRAL;
            unique case (state)
                IDLE: if (pick_valid) begin
                    grant_id <= pick_idx;
                    rr_ptr   <= pick_idx;
                    len_cnt  <= '0;
                    state    <= STREAM;
                end
                STREAM: if (cur_valid) begin
                    chk_char <= cur_char;
                    len_cnt  <= len_nxt;
                    state    <= (cur_char == CH_END) ? DRAIN : (len_nxt == LW'(MAX_LEN)) ? ABORT : STREAM;
                end else begin
                    state <= ABORT;
                end
                DRAIN: state <= CAPTURE;
                CAPTURE: begin
                    res_valid <= grant_oh;
                    res_type  <= chk_format_type;
                    res_abort <= 1'b0;
                    state     <= IDLE;
                end
                ABORT: begin
                    res_valid <= grant_oh;
                    res_type  <= FMT_NONE;
                    res_abort <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_checker_stream_arbiter.sv
// tb_checker_stream_arbiter: directed and random message traffic against a message-level model with a stub checker
module tb_checker_stream_arbiter;
    localparam int NREQ = 2;
    localparam int MAX_LEN = 64;
    localparam string MSG_A = "^242@000030f4: $31 <= 12345678#";
    localparam string MSG_B = "^338@00003130: *00000088 <= ffffb528#";
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [8*NREQ-1:0] req_char = '0;
    logic [NREQ-1:0] req_ready, res_valid;
    logic [1:0] res_type, chk_format_type;
    logic res_abort, busy;
    logic [7:0] chk_char;
    logic [$clog2(NREQ)-1:0] grant_id;
    checker_stream_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_char        (req_char),
        .req_ready       (req_ready),
        .res_valid       (res_valid),
        .res_type        (res_type),
        .res_abort       (res_abort),
        .chk_char        (chk_char),
        .chk_format_type (chk_format_type),
        .busy            (busy),
        .grant_id        (grant_id)
    );
    always #5 clk = ~clk;
    logic has_reg = 1'b0, has_mem = 1'b0;
    logic [1:0] fmt = 2'd0;
    assign chk_format_type = fmt;
    always @(posedge clk) begin
        if (chk_char == "^") begin
            has_reg <= 1'b0;
            has_mem <= 1'b0;
        end
        if (chk_char == "$") has_reg <= 1'b1;
        if (chk_char == "*") has_mem <= 1'b1;
        if (chk_char == "#") fmt <= has_reg ? 2'd1 : has_mem ? 2'd2 : 2'd0;
    end
    int n_cmp = 0, n_bad = 0;
    string mq[NREQ][$];
    int bq[NREQ][$];
    int pos[NREQ];
    bit bubbled[NREQ], acc[NREQ], bub[NREQ];
    int last_owner, term_since;
    int eo[$];
    bit ea[$];
    logic [1:0] et[$];
    string es[$];
    int gl[$];
    string cap;
    bit want_ready_low;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_s(input string tag, input string obs, input string exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask
    function automatic logic [1:0] classify(input string s);
        for (int k = 0; k < s.len(); k++) if (s[k] == "$") return 2'd1;
        for (int k = 0; k < s.len(); k++) if (s[k] == "*") return 2'd2;
        return 2'd0;
    endfunction
    function automatic void outcome(input string m, input int b, output string s, output bit ab, output logic [1:0] ty);
        int lim = (b >= 0) ? b : m.len();
        s = "";
        ab = 1'b1;
        ty = 2'd0;
        for (int k = 0; k < lim && k < MAX_LEN; k++) begin
            s = {s, m.substr(k, k)};
            if (m[k] == "#") begin
                ab = 1'b0;
                ty = classify(s);
                return;
            end
        end
    endfunction
    function automatic int pick_model();
        for (int k = 1; k <= NREQ; k++)
            if (mq[(last_owner + k) % NREQ].size() != 0) return (last_owner + k) % NREQ;
        return -1;
    endfunction
    function automatic bit idle_all();
        for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) return 1'b0;
        return eo.size() == 0 && !busy;
    endfunction
    function automatic string rand_msg();
        case ($urandom_range(2))
            0: return $sformatf("^%0d@%08h: $%0d <= %08h#", $urandom_range(999), $urandom, $urandom_range(31), $urandom);
            1: return $sformatf("^%0d@%08h: *%08h <= %08h#", $urandom_range(999), $urandom, $urandom, $urandom);
            default: return $sformatf("^%0d@%08h: ?? %0d#", $urandom_range(999), $urandom, $urandom_range(99));
        endcase
    endfunction
    task automatic add(input int i, input string m, input int b);
        mq[i].push_back(m);
        bq[i].push_back(b);
    endtask
    task automatic advance(input int i);
        void'(mq[i].pop_front());
        void'(bq[i].pop_front());
        pos[i] = 0;
        bubbled[i] = 1'b0;
    endtask
    task automatic push_outcome(input int i, input string m, input int b);
        string s;
        bit ab;
        logic [1:0] ty;
        outcome(m, b, s, ab, ty);
        eo.push_back(i);
        ea.push_back(ab);
        et.push_back(ty);
        es.push_back(s);
    endtask
    task automatic drive();
        string m;
        for (int i = 0; i < NREQ; i++) begin
            bub[i] = 1'b0;
            req_valid[i] = 1'b0;
            req_char[8*i +: 8] = 8'h00;
            if (mq[i].size() != 0) begin
                m = mq[i][0];
                if (pos[i] < m.len()) begin
                    if (pos[i] == bq[i][0] && !bubbled[i]) begin
                        bubbled[i] = 1'b1;
                        bub[i] = req_ready[i];
                    end else begin
                        req_valid[i] = 1'b1;
                        req_char[8*i +: 8] = m[pos[i]];
                    end
                end else begin
                    bub[i] = req_ready[i];
                end
            end
            acc[i] = req_valid[i] & req_ready[i];
        end
    endtask
    task automatic cycle();
        string m;
        logic [7:0] ch, exp_chk;
        @(negedge clk);
        if (term_since >= 0) term_since++;
        exp_chk = 8'h00;
        want_ready_low = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (bub[i]) term_since = 0;
            if (acc[i]) begin
                m = mq[i][0];
                ch = m[pos[i]];
                exp_chk = ch;
                if (pos[i] == 0) begin
                    chk("grant_owner", i, pick_model());
                    last_owner = i;
                    gl.push_back(i);
                    push_outcome(i, m, bq[i][0]);
                end
                pos[i]++;
                if (ch == "#") begin
                    term_since = 0;
                    advance(i);
                end else if (pos[i] == MAX_LEN) begin
                    term_since = 0;
                    want_ready_low = 1'b1;
                end
            end
        end
        chk("chk_char", chk_char, exp_chk);
        if (chk_char != 8'h00) cap = $sformatf("%s%c", cap, chk_char);
        chk("res_onehot0", $onehot0(res_valid), 1);
        chk("ready_onehot0", $onehot0(req_ready), 1);
        if (want_ready_low) chk("ready_after_maxlen", req_ready, 0);
        if (res_valid != '0) begin
            if (eo.size() == 0) begin
                chk("unexpected_res", res_valid, 0);
            end else begin
                chk("res_valid", res_valid, 1 << eo[0]);
                chk("res_abort", res_abort, ea[0]);
                chk("res_type", res_type, et[0]);
                chk("grant_id", grant_id, eo[0]);
                chk_s("message", cap, es[0]);
                chk("latency", term_since, ea[0] ? 1 : 2);
                if (ea[0]) advance(eo[0]);
                void'(eo.pop_front());
                void'(ea.pop_front());
                void'(et.pop_front());
                void'(es.pop_front());
            end
            cap = "";
            term_since = -1;
        end
        drive();
    endtask
    task automatic run_phase(input int budget, input string tag);
        int n = 0;
        while (n < budget && !idle_all()) begin
            cycle();
            n++;
        end
        chk({tag, "_done"}, n < budget, 1);
        repeat (3) cycle();
    endtask
    task automatic check_zero(input string tag);
        chk({tag, "_chk_char"}, chk_char, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_type"}, res_type, 0);
        chk({tag, "_res_abort"}, res_abort, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        string m;
        int i, b, n;
        term_since = -1;
        last_owner = NREQ - 1;
        cap = "";
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        add(0, MSG_A, -1);
        add(0, MSG_A, -1);
        run_phase(400, "single_req0");
        add(1, MSG_B, -1);
        run_phase(200, "single_req1");
        gl.delete();
        for (int k = 0; k < 6; k++) add(k % 2, rand_msg(), -1);
        run_phase(800, "both");
        chk("order_len", gl.size(), 6);
        for (int k = 0; k < gl.size(); k++) chk("order", gl[k], k % 2);
        gl.delete();
        add(0, MSG_A, 7);
        add(1, MSG_B, -1);
        run_phase(300, "bubble");
        chk("bubble_order_len", gl.size(), 2);
        if (gl.size() == 2) chk("bubble_next_grant", gl[1], 1);
        m = "^";
        for (int k = 0; k < 69; k++) m = {m, "a"};
        add(0, m, -1);
        run_phase(300, "maxlen");
        for (int k = 0; k < 12; k++) begin
            i = $urandom_range(NREQ - 1);
            m = rand_msg();
            b = ($urandom_range(3) == 0) ? $urandom_range(m.len() - 2, 1) : -1;
            add(i, m, b);
        end
        run_phase(2000, "random");
        add(1, rand_msg(), -1);
        add(0, rand_msg(), -1);
        add(1, rand_msg(), -1);
        n = 0;
        while (n < 200 && pos[0] < 5 && pos[1] < 5) begin
            cycle();
            n++;
        end
        chk("midstream_reached", n < 200, 1);
        reset = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            pos[k] = 0;
            bubbled[k] = 1'b0;
            acc[k] = 1'b0;
            bub[k] = 1'b0;
        end
        eo.delete();
        ea.delete();
        et.delete();
        es.delete();
        gl.delete();
        cap = "";
        term_since = -1;
        last_owner = NREQ - 1;
        drive();
        run_phase(800, "after_reset");
        chk("first_grant_after_reset", (gl.size() > 0) ? gl[0] : -1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
